// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode and FSM state encodings
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } alu_state_e;

    function automatic logic is_shift(input alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - single-cycle ALU operations (add..slt)
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_op_e          i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);

    always_comb begin
        o_y = '0;
        case (i_op)
            ALU_ADD: o_y = i_a + i_b;
            ALU_SUB: o_y = i_a - i_b;
            ALU_AND: o_y = i_a & i_b;
            ALU_OR:  o_y = i_a | i_b;
            ALU_XOR: o_y = i_a ^ i_b;
            ALU_SLT: o_y = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - ALU with one-cycle ops and bit-serial shifts
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e       r_state;
    alu_state_e       w_next_state;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [SHW-1:0]   r_cnt;
    logic             r_left;
    logic [WIDTH-1:0] w_comb_y;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_next_result;
    logic [SHW-1:0]   w_amount;
    logic             w_load;
    logic             w_accept_shift;
    alu_op_e          w_op;

    assign w_op      = alu_op_e'(ALUControl);
    assign w_amount  = SrcB[SHW-1:0];
    assign w_shifted = r_left ? (r_work << 1) : (r_work >> 1);

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .i_op (w_op),
        .i_a  (SrcA),
        .i_b  (SrcB),
        .o_y  (w_comb_y)
    );

    // DONE accepts like IDLE so back-to-back ops need no bubble
    always_comb begin
        w_next_state   = r_state;
        w_load         = 1'b0;
        w_next_result  = w_comb_y;
        w_accept_shift = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                w_next_state = IDLE;
                if (start) begin
                    if (is_shift(w_op)) begin
                        w_accept_shift = 1'b1;
                        if (w_amount == '0) begin
                            w_next_state  = DONE;
                            w_load        = 1'b1;
                            w_next_result = SrcA;
                        end else begin
                            w_next_state = SHIFT;
                        end
                    end else begin
                        w_next_state = DONE;
                        w_load       = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (r_cnt == SHW'(1)) begin
                    w_next_state  = DONE;
                    w_load        = 1'b1;
                    w_next_result = w_shifted;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_work   <= '0;
            r_cnt    <= '0;
            r_left   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b1;
        end else begin
            r_state <= w_next_state;
            if (w_accept_shift) begin
                r_work <= SrcA;
                r_cnt  <= w_amount;
                r_left <= (w_op == ALU_SLL);
            end else if (r_state == SHIFT) begin
                r_work <= w_shifted;
                r_cnt  <= r_cnt - SHW'(1);
            end
            if (w_load) begin
                r_result <= w_next_result;
                r_zero   <= (w_next_result == '0);
            end
        end
    end

    assign ready     = (r_state != SHIFT);
    assign done      = (r_state == DONE);
    assign ALUResult = r_result;
    assign Zero      = r_zero;

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - directed-vector bench for multicycle_alu
module tb_multicycle_alu;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [2:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        ready;
    logic        done;
    logic [31:0] ALUResult;
    logic        Zero;

    int n_total;
    int n_bad;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    multicycle_alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ready      (ready),
        .done       (done),
        .ALUResult  (ALUResult),
        .Zero       (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // accept at cycle N, return in cycle N+1 with operands scrambled
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start      = 1'b1;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        tick();
        start      = 1'b0;
        ALUControl = 3'b010;
        SrcA       = 32'hDEAD_BEEF;
        SrcB       = 32'h1234_5678;
    endtask

    // called in cycle N+1; lat = cycles from accept to done
    task automatic wait_done(input string tag, output int lat, output int busy);
        lat  = 1;
        busy = 0;
        while (!done && lat <= 40) begin
            if (!ready) busy++;
            tick();
            lat++;
        end
        if (!done) begin
            n_total++;
            n_bad++;
            $display("FAIL %s timeout got=no_done exp=done", tag);
        end
    endtask

    int lat;
    int busy;
    int n_done;

    initial begin
        n_total    = 0;
        n_bad      = 0;
        resetn     = 1'b0;
        start      = 1'b0;
        ALUControl = 3'b000;
        SrcA       = '0;
        SrcB       = '0;
        repeat (3) tick();
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", ALUResult, 32'h0);
        check("rst_zero", {31'd0, Zero}, 32'd1);
        resetn = 1'b1;
        tick();

        issue(OP_ADD, 32'h0000_0005, 32'hFFFF_FFFB);
        check("add_done_n1", {31'd0, done}, 32'd1);
        check("add_result", ALUResult, 32'h0);
        check("add_zero", {31'd0, Zero}, 32'd1);
        tick();
        check("add_done_pulse", {31'd0, done}, 32'd0);
        check("add_idle_ready", {31'd0, ready}, 32'd1);

        issue(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001);
        check("slt_done", {31'd0, done}, 32'd1);
        check("slt_neg_lt", ALUResult, 32'h1);
        check("slt_zero0", {31'd0, Zero}, 32'd0);
        tick();
        issue(OP_SLT, 32'h0000_0001, 32'hFFFF_FFFF);
        check("slt_swap", ALUResult, 32'h0);
        tick();

        issue(OP_SLL, 32'h0000_0001, 32'h0000_001F);
        check("sll_hold", ALUResult, 32'h0);
        wait_done("sll31", lat, busy);
        check("sll31_lat", lat, 32);
        check("sll31_busy", busy, 31);
        check("sll31_result", ALUResult, 32'h8000_0000);
        tick();

        issue(OP_SRL, 32'h8000_0000, 32'h0000_0000);
        check("srl0_done_n1", {31'd0, done}, 32'd1);
        check("srl0_result", ALUResult, 32'h8000_0000);
        tick();

        // only SrcB[4:0] counts: 0x21 is a shift by one
        issue(OP_SRL, 32'h8000_0000, 32'h0000_0021);
        wait_done("srl1", lat, busy);
        check("srl1_lat", lat, 2);
        check("srl1_result", ALUResult, 32'h4000_0000);
        tick();

        start      = 1'b1;
        ALUControl = OP_SRL;
        SrcA       = 32'hF000_0000;
        SrcB       = 32'h0000_0004;
        tick();
        ALUControl = OP_XOR;
        SrcA       = 32'h0000_FFFF;
        SrcB       = 32'h00FF_00FF;
        wait_done("srl4", lat, busy);
        check("srl4_lat", lat, 5);
        check("srl4_result", ALUResult, 32'h0F00_0000);
        tick();
        start = 1'b0;
        check("xor_after_done", {31'd0, done}, 32'd1);
        check("xor_result", ALUResult, 32'h00FF_FF00);
        tick();
        check("xor_pulse", {31'd0, done}, 32'd0);

        issue(OP_SLL, 32'h0000_0001, 32'h0000_000A);
        repeat (3) tick();
        check("rst_mid_busy", {31'd0, ready}, 32'd0);
        resetn     = 1'b0;
        start      = 1'b1;
        ALUControl = OP_ADD;
        SrcA       = 32'h1;
        SrcB       = 32'h1;
        tick();
        resetn = 1'b1;
        start  = 1'b0;
        check("rst_mid_ready", {31'd0, ready}, 32'd1);
        check("rst_mid_result", ALUResult, 32'h0);
        check("rst_mid_zero", {31'd0, Zero}, 32'd1);
        n_done = 0;
        repeat (14) begin
            if (done) n_done++;
            tick();
        end
        check("rst_mid_no_done", n_done, 0);

        start      = 1'b1;
        ALUControl = OP_SUB;
        SrcA       = 32'd3;
        SrcB       = 32'd5;
        tick();
        ALUControl = OP_OR;
        SrcA       = 32'h0000_00F0;
        SrcB       = 32'h0000_000F;
        check("b2b_sub_done", {31'd0, done}, 32'd1);
        check("b2b_sub_result", ALUResult, 32'hFFFF_FFFE);
        tick();
        start = 1'b0;
        check("b2b_or_done", {31'd0, done}, 32'd1);
        check("b2b_or_result", ALUResult, 32'h0000_00FF);
        tick();
        check("b2b_idle", {31'd0, done}, 32'd0);
        check("b2b_hold", ALUResult, 32'h0000_00FF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
